// File: rtl/sram_loader_pkg.sv
// Shared types and constants for the SRAM byte-stream loader.
// The loader FSM state encoding and the byte lane width live here.
package sram_loader_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sram_stream_loader_byte_packer.sv
// Packs incoming bytes little-endian into one SRAM word and accumulates
// the byte-enable mask for the lanes that have been filled.
module byte_packer
    import sram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [BYTE_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] word,
    output logic [NUM_WMASKS-1:0] mask,
    output logic                  lane_last
);

    localparam int LANE_W = (NUM_WMASKS > 1) ? $clog2(NUM_WMASKS) : 1;

    logic [LANE_W-1:0] lane;

    assign lane_last = (lane == LANE_W'(NUM_WMASKS - 1));

    // NOTE: the word register is a handful of flops, not a RAM, so it is reset;
    // clearing it also guarantees unfilled lanes are written as zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word <= '0;
            mask <= '0;
            lane <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_WMASKS; k++) begin
                if (lane == LANE_W'(k)) begin
                    word[k*BYTE_WIDTH +: BYTE_WIDTH] <= data;
                    mask[k]                          <= 1'b1;
                end
            end
            lane <= lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/sram_stream_loader.sv
// Loads a byte stream into an SRAM through port 0, one packed word at a time,
// starting at a caller-supplied base address and wrapping at the top of memory.
module sram_stream_loader
    import sram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [BYTE_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH:0] COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   addr_hold;
    logic [DATA_WIDTH-1:0]   din_hold;
    logic                    last_seen;
    logic                    accept;
    logic                    pack_clear;
    logic                    lane_last;
    logic [DATA_WIDTH-1:0]   pack_word;
    logic [NUM_WMASKS-1:0]   pack_mask;

    assign accept     = (state == ST_FILL) && in_valid;
    assign pack_clear = ((state == ST_IDLE) && start) || (state == ST_WRITE);

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WMASKS (NUM_WMASKS)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .accept    (accept),
        .data      (in_data),
        .word      (pack_word),
        .mask      (pack_mask),
        .lane_last (lane_last)
    );

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_FILL;
            ST_FILL:  if (accept && (lane_last || in_last)) state_next = ST_WRITE;
            ST_WRITE: state_next = last_seen ? ST_DONE : ST_FILL;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            addr_hold  <= '0;
            din_hold   <= '0;
            last_seen  <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ptr        <= base_addr;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        last_seen  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (accept && in_last) last_seen <= 1'b1;
                end
                ST_WRITE: begin
                    addr_hold <= ptr;
                    din_hold  <= pack_word;
                    ptr       <= ptr + ADDR_WIDTH'(1);
                    // A full count means this write landed on the load's first word again.
                    if (word_count == COUNT_FULL) overflow <= 1'b1;
                    else word_count <= word_count + (ADDR_WIDTH+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Port 0 drives the live pointer/word only during WRITE and holds the last write otherwise.
    assign in_ready = (state == ST_FILL);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign csb0     = (state != ST_WRITE);
    assign web0     = (state != ST_WRITE);
    assign wmask0   = (state == ST_WRITE) ? pack_mask : '0;
    assign addr0    = (state == ST_WRITE) ? ptr : addr_hold;
    assign din0     = (state == ST_WRITE) ? pack_word : din_hold;

endmodule

// File: tb/tb_sram_stream_loader.sv
// Scoreboard bench for sram_stream_loader: a byte-packing model queues the
// expected SRAM writes, and a negedge monitor pops and compares each write.
module tb_sram_stream_loader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NM = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NM-1:0] mask;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_last;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          csb0;
    logic          web0;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    wr_t        sb[$];
    logic [7:0] stim_q[$];
    int         exp_count;
    logic       exp_ovf;

    sram_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .csb0       (csb0),
        .web0       (web0),
        .wmask0     (wmask0),
        .addr0      (addr0),
        .din0       (din0),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor and done-pulse counter.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (csb0 === 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {54'd0, addr0}, 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(addr0), 64'(e.addr));
                check("wr_data", 64'(din0), 64'(e.data));
                check("wr_mask", 64'(wmask0), 64'(e.mask));
                check("wr_web0", 64'(web0), 64'd0);
            end
        end
    end

    // Reference model: pack stim_q into expected writes starting at base.
    task automatic model_load(input logic [AW-1:0] base);
        logic [AW-1:0] p;
        logic [DW-1:0] w;
        logic [NM-1:0] m;
        int lane;
        int words;
        p = base; w = '0; m = '0; lane = 0; words = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            w[lane*8 +: 8] = stim_q[i];
            m[lane] = 1'b1;
            lane++;
            if (lane == NM || i == stim_q.size() - 1) begin
                sb.push_back('{addr: p, data: w, mask: m});
                p = p + AW'(1);
                w = '0; m = '0; lane = 0;
                words++;
            end
        end
        exp_count = (words > (1 << AW)) ? (1 << AW) : words;
        exp_ovf   = (words > (1 << AW));
    endtask

    task automatic pulse_start(input logic [AW-1:0] base);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic run_load(input string name, input logic [AW-1:0] base);
        int d0;
        model_load(base);
        d0 = done_cnt;
        pulse_start(base);
        for (int i = 0; i < stim_q.size(); i++)
            send_byte(stim_q[i], i == stim_q.size() - 1);
        wait_idle();
        @(negedge clk);
        check({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_word_count"}, 64'(word_count), 64'(exp_count));
        check({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; base_addr = '0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_csb0", 64'(csb0), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);

        // Single full word, last on lane 3.
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load("full_word", 10'h010);

        // One full word then a two-byte partial word.
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_load("partial", 10'h005);

        // Reset after two bytes: no write, everything back to reset values.
        pulse_start(10'h123);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_csb0", 64'(csb0), 64'd1);
        check("abort_web0", 64'(web0), 64'd1);
        check("abort_wmask0", 64'(wmask0), 64'd0);
        check("abort_addr0", 64'(addr0), 64'd0);
        check("abort_din0", 64'(din0), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_word_count", 64'(word_count), 64'd0);
        check("abort_sb", 64'(sb.size()), 64'd0);

        // Single byte with last on lane 0.
        stim_q = '{8'h5A};
        run_load("lane0_last", 10'h07F);

        // Wrap from the top address.
        stim_q = {};
        for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
        run_load("wrap", 10'h3FF);

        // In IDLE: in_valid without start is not accepted.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", 64'(in_ready), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
        in_valid = 1'b0;

        // start while busy is ignored: writes stay at the first base address.
        stim_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        model_load(10'h100);
        d0 = done_cnt;
        pulse_start(10'h100);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        pulse_start(10'h200);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hC4, 1'b1);
        wait_idle();
        @(negedge clk);
        check("busy_start_sb", 64'(sb.size()), 64'd0);
        check("busy_start_done", 64'(done_cnt - d0), 64'd1);
        check("busy_start_count", 64'(word_count), 64'd1);

        // 1025 full words from address 0: last write wraps onto the first word.
        stim_q = {};
        for (int i = 0; i < 4 * 1025; i++) stim_q.push_back(8'(i * 7 + 3));
        run_load("overflow", 10'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
